// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// The master issues operands and start; the slave reports busy/done and the result.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, processing the operands
// LSB-first at one bit per clock and publishing {cout,sum} on completion.
//
// state  | meaning
// IDLE   | waiting for start; result outputs hold the last completed addition
// RUN    | one operand bit pair added per clock, WIDTH clocks in total
// DONE   | single-cycle done pulse; a start here is accepted back-to-back
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic fa_s;
  logic fa_co;

  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    full_add = {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  always_comb begin
    {fa_co, fa_s} = full_add(a_q[0], b_q[0], carry_q);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        // Result bits enter at the MSB so that after WIDTH shifts bit 0 is the first sum bit.
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          sum_d   = {fa_s, res_q[WIDTH-1:1]};
          cout_d  = fa_co;
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.busy = (state_q == S_RUN);
  assign bus.done = (state_q == S_DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: the driver queues expected {cout,sum} per start,
// a monitor pops and compares on every done pulse and watches busy/done/sum behaviour.
module tb_serial_adder;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder_if #(.WIDTH(WIDTH)) bus ();

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [WIDTH:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic void check(input string name, input logic [WIDTH:0] act, input logic [WIDTH:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: result scoreboard, busy length, busy/done exclusion, result stability while busy.
  initial begin : monitor
    int             busy_len;
    logic [WIDTH:0] prev_res;
    logic [WIDTH:0] e;
    busy_len = 0;
    prev_res = '0;
    forever begin
      @(negedge clk);
      if (bus.busy || bus.done)
        check("busy_done_exclusive", {8'd0, bus.busy & bus.done}, 9'd0);
      if (bus.busy)
        check("result_stable_in_run", {bus.cout, bus.sum}, prev_res);
      if (bus.done) begin
        check("busy_length", 9'(busy_len), 9'(WIDTH));
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: got done with result 0x%0h, expected no done (cycle %0d)",
                   {bus.cout, bus.sum}, cyc);
        end else begin
          e = exp_q.pop_front();
          check("result", {bus.cout, bus.sum}, e);
        end
      end
      busy_len = bus.busy ? busy_len + 1 : 0;
      prev_res = {bus.cout, bus.sum};
    end
  end

  task automatic wait_done(output int at_cyc);
    int k;
    k = 0;
    at_cyc = -1;
    while (k < 4 * WIDTH) begin
      @(negedge clk);
      if (bus.done) begin
        at_cyc = cyc;
        break;
      end
      k++;
    end
    if (at_cyc < 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got no done within %0d cycles, expected one", 4 * WIDTH);
    end
  endtask

  task automatic run_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic ci, input logic [WIDTH:0] exp);
    int t;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = ci;
    bus.start = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(t);
  endtask

  initial begin : driver
    int             t1;
    int             t2;
    bit             seen;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic           rc;

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {8'd0, bus.busy}, 9'd0);
    check("reset_done", {8'd0, bus.done}, 9'd0);
    check("reset_result", {bus.cout, bus.sum}, 9'h000);
    rst = 1'b0;

    run_add(8'h3C, 8'h5A, 1'b0, 9'h096);
    run_add(8'hFF, 8'h01, 1'b0, 9'h100);
    run_add(8'hFF, 8'hFF, 1'b1, 9'h1FF);

    // Reset in the 4th busy cycle: no done, result cleared.
    bus.a     = 8'h80;
    bus.b     = 8'h80;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy", {8'd0, bus.busy}, 9'd0);
    check("abort_done", {8'd0, bus.done}, 9'd0);
    check("abort_result", {bus.cout, bus.sum}, 9'h000);
    repeat (2 * WIDTH) @(negedge clk);

    run_add(8'h00, 8'h00, 1'b0, 9'h000);

    // Operand and start noise while busy must not disturb 0x12+0x34.
    bus.a     = 8'h12;
    bus.b     = 8'h34;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    exp_q.push_back(9'h046);
    @(posedge clk);
    #1;
    seen = 1'b0;
    for (int k = 0; k < 4 * WIDTH; k++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if ((k % 2) == 0) begin
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
      end else begin
        bus.start = 1'b0;
        bus.a     = 8'($urandom);
        bus.b     = 8'($urandom);
      end
      bus.cin = ~bus.cin;
    end
    bus.start = 1'b0;
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL noise_done_timeout: got no done, expected one");
    end
    repeat (2 * WIDTH) @(negedge clk);

    // start held high: second operands presented in the DONE cycle.
    bus.a     = 8'h01;
    bus.b     = 8'h01;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    exp_q.push_back(9'h002);
    wait_done(t1);
    bus.a = 8'h02;
    bus.b = 8'h03;
    exp_q.push_back(9'h005);
    wait_done(t2);
    bus.start = 1'b0;
    check("done_spacing", 9'(t2 - t1), 9'(WIDTH + 1));
    repeat (3) @(negedge clk);

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      run_add(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {8'd0, rc});
    end

    repeat (2 * WIDTH) @(negedge clk);
    check("scoreboard_drained", 9'(exp_q.size()), 9'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
